// File: rtl/debug_loader.sv
// Program-load front end: frames a byte stream into 32-bit words and
// drives the IMEM debug write port while holding the core in reset.
module debug_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          MAX_WORDS      = 1024,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        DEBUG_SIG,
  output logic [31:0] DEBUG_addr,
  output logic [31:0] DEBUG_instr,
  output logic        debug_we,
  output logic        core_nrst,
  output logic        done,
  output logic        err
);

  localparam int CW = $clog2(MAX_WORDS + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE, CNT_LO, CNT_HI, DATA, WRITE, CSUM
  } state_t;

  state_t        state;
  logic [7:0]    cnt_lo;
  logic [7:0]    csum;
  logic [CW-1:0] n_words;
  logic [CW-1:0] wcnt;
  logic [1:0]    idx;
  logic [TW-1:0] tmo;

  logic        acc;
  logic [15:0] n16;
  logic        bad_n;
  logic        timed;
  logic        tmo_hit;

  assign acc   = rx_valid && rx_ready;
  assign n16   = {rx_data, cnt_lo};
  assign bad_n = (n16 == 16'd0) ||
                 ({16'd0, n16} > 32'(MAX_WORDS));
  assign timed = (state == CNT_LO) || (state == CNT_HI) ||
                 (state == DATA)   || (state == CSUM);
  assign tmo_hit = timed && !acc &&
                   (tmo == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state       <= IDLE;
      rx_ready    <= 1'b0;
      DEBUG_SIG   <= 1'b0;
      DEBUG_addr  <= 32'd0;
      DEBUG_instr <= 32'd0;
      debug_we    <= 1'b0;
      core_nrst   <= 1'b0;
      done        <= 1'b0;
      err         <= 1'b0;
      cnt_lo      <= 8'd0;
      csum        <= 8'd0;
      n_words     <= '0;
      wcnt        <= '0;
      idx         <= 2'd0;
      tmo         <= '0;
    end else begin
      done     <= 1'b0;
      debug_we <= 1'b0;
      rx_ready <= 1'b1;
      if (timed)
        tmo <= acc ? '0 : tmo + TW'(1);
      unique case (state)
        IDLE: begin
          // rx_ready is only low in IDLE on the first cycle out of reset
          if (!rx_ready)
            core_nrst <= 1'b1;
          if (acc && rx_data == 8'hA5) begin
            DEBUG_SIG  <= 1'b1;
            core_nrst  <= 1'b0;
            err        <= 1'b0;
            DEBUG_addr <= BASE_ADDR;
            idx        <= 2'd0;
            csum       <= 8'd0;
            wcnt       <= '0;
            tmo        <= '0;
            state      <= CNT_LO;
          end
        end
        CNT_LO: begin
          if (acc) begin
            cnt_lo <= rx_data;
            state  <= CNT_HI;
          end
        end
        CNT_HI: begin
          if (acc) begin
            if (bad_n) begin
              err       <= 1'b1;
              DEBUG_SIG <= 1'b0;
              state     <= IDLE;
            end else begin
              n_words <= CW'(n16);
              state   <= DATA;
            end
          end
        end
        DATA: begin
          if (acc) begin
            DEBUG_instr <= {rx_data, DEBUG_instr[31:8]};
            csum        <= csum ^ rx_data;
            idx         <= idx + 2'd1;
            if (idx == 2'd3) begin
              debug_we <= 1'b1;
              rx_ready <= 1'b0;
              state    <= WRITE;
            end
          end
        end
        WRITE: begin
          DEBUG_addr <= DEBUG_addr + 32'd4;
          wcnt       <= wcnt + CW'(1);
          state      <= (wcnt + CW'(1) == n_words) ? CSUM : DATA;
        end
        CSUM: begin
          if (acc) begin
            DEBUG_SIG <= 1'b0;
            state     <= IDLE;
            if (rx_data == csum) begin
              done      <= 1'b1;
              core_nrst <= 1'b1;
            end else begin
              err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
      if (tmo_hit) begin
        err       <= 1'b1;
        DEBUG_SIG <= 1'b0;
        state     <= IDLE;
      end
    end
  end

endmodule
